// File: rtl/axis2fifo_pkg.sv
// axis2fifo_pkg: shared state encoding and width derivations for the
// AXI4-Stream to FIFO-write packer.
package axis2fifo_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    // Ceiling log2; clogb2(1) = 0.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Number of stream beats packed into one FIFO word.
    function automatic int ratio_of(input int axi4_w, input int axis_w);
        return axi4_w / axis_w;
    endfunction

    // Lane counter width, never narrower than one bit.
    function automatic int lane_w_of(input int ratio);
        return (ratio > 1) ? clogb2(ratio) : 1;
    endfunction

endpackage

// File: rtl/axis2fifo_lane_buf.sv
// axis2fifo_lane_buf: holds the partially packed FIFO word and its keep mask.
// nxt_dat/nxt_keep present the word as it looks with the current beat merged,
// so the top can register a completed word without waiting a cycle.
module axis2fifo_lane_buf
    import axis2fifo_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH = 128,
    parameter int RATIO           = 4,
    parameter int LANE_W          = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               ld,
    input  logic                               flush,
    input  logic [LANE_W-1:0]                  lane,
    input  logic [AXIS_DATA_WIDTH-1:0]         in_dat,
    input  logic [AXIS_DATA_WIDTH/BYTE_W-1:0]  in_keep,
    output logic [AXI4_DATA_WIDTH-1:0]         nxt_dat,
    output logic [AXI4_DATA_WIDTH/BYTE_W-1:0]  nxt_keep
);

    localparam int SW = AXIS_DATA_WIDTH / BYTE_W;
    localparam int KW = AXI4_DATA_WIDTH / BYTE_W;

    logic [AXI4_DATA_WIDTH-1:0] lane_dat;
    logic [KW-1:0]              lane_keep;

    // Merge the incoming beat into its lane; a start beat drops held lanes first.
    always_comb begin
        nxt_dat  = start ? '0 : lane_dat;
        nxt_keep = start ? '0 : lane_keep;
        for (int i = 0; i < RATIO; i++) begin
            if (ld && (lane == LANE_W'(i))) begin
                nxt_dat[AXI4_DATA_WIDTH-1-i*AXIS_DATA_WIDTH -: AXIS_DATA_WIDTH] = in_dat;
                nxt_keep[KW-1-i*SW -: SW] = in_keep;
            end
        end
    end

    // Hold the merged word until it is flushed out as a FIFO write.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            lane_dat  <= '0;
            lane_keep <= '0;
        end else if (ld) begin
            lane_dat  <= nxt_dat;
            lane_keep <= nxt_keep;
        end
    end

endmodule

// File: rtl/axis2fifo_pack.sv
// axis2fifo_pack: packs RATIO narrow AXI4-Stream beats into one FIFO word,
// frame-scoped (opens on TUSER, closes on TLAST, partial last word with keep).
// Optional statistics counters are built when AXIS2FIFO_PACK_STAT_EN is defined.
module axis2fifo_pack
    import axis2fifo_pkg::*;
#(
    parameter int FAW             = 8,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH = 128,
    parameter int FULL_MARGIN     = 2
) (
    input  logic                               S_AXIS_ACLK,
    input  logic                               S_AXIS_ARESET,
    output logic                               S_AXIS_TREADY,
    input  logic [AXIS_DATA_WIDTH-1:0]         S_AXIS_TDATA,
    input  logic [AXIS_DATA_WIDTH/BYTE_W-1:0]  S_AXIS_TSTRB,
    input  logic                               S_AXIS_TLAST,
    input  logic                               S_AXIS_TVALID,
    input  logic                               S_AXIS_USER,
    input  logic                               fwr_rdy,
    input  logic                               fwr_full,
    input  logic [FAW:0]                       fwr_cnt,
    output logic                               fwr_vld,
    output logic [AXI4_DATA_WIDTH-1:0]         fwr_dat,
    output logic [AXI4_DATA_WIDTH/BYTE_W-1:0]  fwr_keep,
    output logic                               fwr_last
`ifdef AXIS2FIFO_PACK_STAT_EN
    ,
    output logic [31:0]                        stat_frames,
    output logic [31:0]                        stat_drops
`endif
);

    localparam int RATIO  = ratio_of(AXI4_DATA_WIDTH, AXIS_DATA_WIDTH);
    localparam int LANE_W = lane_w_of(RATIO);
    localparam int KW     = AXI4_DATA_WIDTH / BYTE_W;
    // Highest occupancy that still leaves FULL_MARGIN free words.
    localparam logic [FAW:0] CNT_MAX = (FAW+1)'((1 << FAW) - FULL_MARGIN);

    state_t                     state;
    state_t                     state_nxt;
    logic [LANE_W-1:0]          lane_cnt;
    logic [LANE_W-1:0]          lane_sel;
    logic                       tready;
    logic                       accept;
    logic                       pack;
    logic                       start;
    logic                       emit;
    logic [AXI4_DATA_WIDTH-1:0] nxt_dat;
    logic [KW-1:0]              nxt_keep;

    logic                       wr_vld_p1;
    logic [AXI4_DATA_WIDTH-1:0] wr_dat_p1;
    logic [KW-1:0]              wr_keep_p1;
    logic                       wr_last_p1;

    // Backpressure only looks at the FIFO side, never at TVALID.
    assign tready        = ~S_AXIS_ARESET & fwr_rdy & ~fwr_full & (fwr_cnt <= CNT_MAX);
    assign S_AXIS_TREADY = tready;
    assign accept        = S_AXIS_TVALID & tready;

    // State register.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: USER opens a frame, TLAST closes it (single-beat frames never leave IDLE).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept && S_AXIS_USER && !S_AXIS_TLAST) state_nxt = ST_FRAME;
            ST_FRAME: if (accept && S_AXIS_TLAST) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Beat decode: which accepted beats are packed and which restart at lane 0.
    always_comb begin
        pack  = 1'b0;
        start = 1'b0;
        case (state)
            ST_IDLE: begin
                start = accept & S_AXIS_USER;
                pack  = accept & S_AXIS_USER;
            end
            ST_FRAME: begin
                start = accept & S_AXIS_USER;
                pack  = accept;
            end
            default: begin
                pack  = 1'b0;
                start = 1'b0;
            end
        endcase
    end

    assign lane_sel = start ? '0 : lane_cnt;
    assign emit     = pack & ((lane_sel == LANE_W'(RATIO - 1)) | S_AXIS_TLAST);

    // Lane counter advances per packed beat and wraps on every emitted word.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            lane_cnt <= '0;
        end else if (pack) begin
            lane_cnt <= emit ? '0 : lane_sel + LANE_W'(1);
        end
    end

    axis2fifo_lane_buf #(
        .AXIS_DATA_WIDTH (AXIS_DATA_WIDTH),
        .AXI4_DATA_WIDTH (AXI4_DATA_WIDTH),
        .RATIO           (RATIO),
        .LANE_W          (LANE_W)
    ) u_lane_buf (
        .clk      (S_AXIS_ACLK),
        .rst      (S_AXIS_ARESET),
        .start    (start),
        .ld       (pack),
        .flush    (emit),
        .lane     (lane_sel),
        .in_dat   (S_AXIS_TDATA),
        .in_keep  (S_AXIS_TSTRB),
        .nxt_dat  (nxt_dat),
        .nxt_keep (nxt_keep)
    );

    // Write stage: completed word goes out one cycle after its last beat; idle bus is zero.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            wr_vld_p1  <= 1'b0;
            wr_dat_p1  <= '0;
            wr_keep_p1 <= '0;
            wr_last_p1 <= 1'b0;
        end else begin
            wr_vld_p1  <= emit;
            wr_dat_p1  <= emit ? nxt_dat : '0;
            wr_keep_p1 <= emit ? nxt_keep : '0;
            wr_last_p1 <= emit & S_AXIS_TLAST;
        end
    end

    assign fwr_vld  = wr_vld_p1;
    assign fwr_dat  = wr_dat_p1;
    assign fwr_keep = wr_keep_p1;
    assign fwr_last = wr_last_p1;

`ifdef AXIS2FIFO_PACK_STAT_EN
    logic drop_idle;
    logic restart;
    logic disc_run;

    assign drop_idle = accept & (state == ST_IDLE) & ~S_AXIS_USER;
    assign restart   = accept & (state == ST_FRAME) & S_AXIS_USER;

    // Frame and drop counters; a run of discarded IDLE beats counts as one drop.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            stat_frames <= '0;
            stat_drops  <= '0;
            disc_run    <= 1'b0;
        end else begin
            if (wr_vld_p1 && wr_last_p1) begin
                stat_frames <= stat_frames + 32'd1;
            end
            if ((drop_idle && !disc_run) || restart) begin
                stat_drops <= stat_drops + 32'd1;
            end
            if (drop_idle) begin
                disc_run <= ~S_AXIS_TLAST;
            end else if (accept) begin
                disc_run <= 1'b0;
            end
        end
    end
`endif

endmodule
